// File: rtl/multicycle_ctrl_ws.sv
// Multicycle MIPS-subset controller: opcode decode plus the control FSM that
// sequences the shared PC/IR/regfile/ALU/memory datapath, with memory wait states.
//
// state  | meaning
// FETCH  | read instruction at PC, PC <= PC+4 (waits on memory)
// DECODE | register read, branch target into ALUOut
// MEMADR | effective address for lw/sw
// MEMRD  | data read (waits on memory)
// MEMWB  | load result into rt
// MEMWR  | data write (waits on memory)
// RTEX   | R-type ALU operation
// RTWB   | R-type result into rd
// IMMEX  | addi/andi/slti ALU operation
// IMMWB  | immediate result into rt
// BRANCH | beq/bne compare and conditional PC update
// JUMP   | j
// JAL    | jal: PC <= target, r31 <= PC
// JR     | jr: PC <= A
// TRAP   | illegal opcode, held until reset
module multicycle_ctrl_ws #(
  parameter int               OPC_W    = 6,
  parameter bit               STALL_EN = 1'b1,
  parameter bit               TRAP_EN  = 1'b1,
  parameter logic [OPC_W-1:0] OPC_JR   = OPC_W'(6'b000110)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [OPC_W-1:0] opc,
  input  logic             mem_ready,
  output logic             PCWrite,
  output logic             PCWriteCondBeq,
  output logic             PCWriteCondBne,
  output logic             IorD,
  output logic             IRWrite,
  output logic             RegDst,
  output logic             JalSig1,
  output logic             JalSig2,
  output logic             MemToReg,
  output logic             MemRead,
  output logic             MemWrite,
  output logic             RegWrite,
  output logic             ALUSrcA,
  output logic [1:0]       ALUSrcB,
  output logic [2:0]       ALUOp,
  output logic [1:0]       PCSrc,
  output logic             trap,
  output logic             instr_done
);

  localparam logic [OPC_W-1:0] OP_RT   = OPC_W'(6'b000000);
  localparam logic [OPC_W-1:0] OP_LW   = OPC_W'(6'b100011);
  localparam logic [OPC_W-1:0] OP_SW   = OPC_W'(6'b101011);
  localparam logic [OPC_W-1:0] OP_BEQ  = OPC_W'(6'b000100);
  localparam logic [OPC_W-1:0] OP_BNE  = OPC_W'(6'b000101);
  localparam logic [OPC_W-1:0] OP_J    = OPC_W'(6'b000010);
  localparam logic [OPC_W-1:0] OP_JAL  = OPC_W'(6'b000011);
  localparam logic [OPC_W-1:0] OP_ADDI = OPC_W'(6'b001000);
  localparam logic [OPC_W-1:0] OP_ANDI = OPC_W'(6'b001100);
  localparam logic [OPC_W-1:0] OP_SLTI = OPC_W'(6'b001010);

  typedef enum logic [3:0] {
    FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, RTEX, RTWB,
    IMMEX, IMMWB, BRANCH, JUMP, JAL, JR, TRAP
  } state_t;

  state_t state;
  state_t decNext;
  logic   illegal;
  logic   rdy;

  assign rdy = STALL_EN ? mem_ready : 1'b1;

  always_comb begin
    decNext = TRAP_EN ? TRAP : FETCH;
    illegal = 1'b0;
    if (opc == OP_LW || opc == OP_SW)                           decNext = MEMADR;
    else if (opc == OP_RT)                                      decNext = RTEX;
    else if (opc == OP_ADDI || opc == OP_ANDI || opc == OP_SLTI) decNext = IMMEX;
    else if (opc == OP_BEQ || opc == OP_BNE)                    decNext = BRANCH;
    else if (opc == OP_J)                                       decNext = JUMP;
    else if (opc == OP_JAL)                                     decNext = JAL;
    else if (opc == OPC_JR)                                     decNext = JR;
    else                                                        illegal = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= FETCH;
    end else begin
      case (state)
        FETCH:   if (rdy) state <= DECODE;
        DECODE:  state <= decNext;
        MEMADR:  state <= (opc == OP_SW) ? MEMWR : MEMRD;
        MEMRD:   if (rdy) state <= MEMWB;
        MEMWR:   if (rdy) state <= FETCH;
        RTEX:    state <= RTWB;
        IMMEX:   state <= IMMWB;
        TRAP:    state <= TRAP;
        default: state <= FETCH;
      endcase
    end
  end

  // Outputs are forced low while rst is high, so nothing writes after the reset edge.
  always_comb begin
    PCWrite        = 1'b0;
    PCWriteCondBeq = 1'b0;
    PCWriteCondBne = 1'b0;
    IorD           = 1'b0;
    IRWrite        = 1'b0;
    RegDst         = 1'b0;
    JalSig1        = 1'b0;
    JalSig2        = 1'b0;
    MemToReg       = 1'b0;
    MemRead        = 1'b0;
    MemWrite       = 1'b0;
    RegWrite       = 1'b0;
    ALUSrcA        = 1'b0;
    ALUSrcB        = 2'b00;
    ALUOp          = 3'b000;
    PCSrc          = 2'b00;
    trap           = 1'b0;
    instr_done     = 1'b0;
    if (!rst) begin
      case (state)
        FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 2'b01;
          IRWrite = rdy;
          PCWrite = rdy;
        end
        DECODE: begin
          ALUSrcB    = 2'b11;
          instr_done = illegal && !TRAP_EN;
        end
        MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
        end
        MEMRD: begin
          MemRead = 1'b1;
          IorD    = 1'b1;
        end
        MEMWB: begin
          RegWrite   = 1'b1;
          MemToReg   = 1'b1;
          instr_done = 1'b1;
        end
        MEMWR: begin
          MemWrite   = 1'b1;
          IorD       = 1'b1;
          instr_done = rdy;
        end
        RTEX: begin
          ALUSrcA = 1'b1;
          ALUOp   = 3'b010;
        end
        RTWB: begin
          RegDst     = 1'b1;
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        IMMEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 2'b10;
          ALUOp   = (opc == OP_ANDI) ? 3'b011 :
                    (opc == OP_SLTI) ? 3'b100 : 3'b000;
        end
        IMMWB: begin
          RegWrite   = 1'b1;
          instr_done = 1'b1;
        end
        BRANCH: begin
          ALUSrcA        = 1'b1;
          ALUOp          = 3'b001;
          PCSrc          = 2'b01;
          PCWriteCondBeq = (opc == OP_BEQ);
          PCWriteCondBne = (opc == OP_BNE);
          instr_done     = 1'b1;
        end
        JUMP: begin
          PCWrite    = 1'b1;
          PCSrc      = 2'b10;
          instr_done = 1'b1;
        end
        JAL: begin
          PCWrite    = 1'b1;
          PCSrc      = 2'b10;
          RegWrite   = 1'b1;
          JalSig1    = 1'b1;
          JalSig2    = 1'b1;
          instr_done = 1'b1;
        end
        JR: begin
          PCWrite    = 1'b1;
          PCSrc      = 2'b11;
          instr_done = 1'b1;
        end
        TRAP:    trap = 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: doc/multicycle_ctrl_ws.md
Name: multicycle_ctrl_ws

Overview:
Next-generation multicycle MIPS-subset controller: opcode decode and the control state machine in one Moore/Mealy FSM. Drives the existing multicycle datapath (PC, IR, register file, ALU, unified memory). Relative to the previous controller it adds:
- memory wait-state handshake (mem_ready)
- slti support
- a 3-bit ALUOp
- parametrised jr opcode
- illegal-opcode trap
- per-instruction completion strobe

Parameters:
OPC_W, 6, opcode width
STALL_EN, 1, 1: honour mem_ready; 0: memory treated as always ready
TRAP_EN, 1, 1: illegal opcode enters TRAP; 0: illegal opcode executes as NOP
OPC_JR, 6'b000110, opcode of jr

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
opc  in  OPC_W  IR[31:26], stable from DECODE onward
mem_ready  in  1  memory completes access this cycle
PCWrite, PCWriteCondBeq, PCWriteCondBne, IorD, IRWrite, RegDst, JalSig1, JalSig2, MemToReg, MemRead, MemWrite, RegWrite, ALUSrcA  out  1 each  datapath controls, existing meanings
ALUSrcB  out  2  00 B, 01 const 4, 10 sext imm, 11 sext imm<<2
ALUOp  out  3  000 add, 001 sub, 010 funct, 011 and, 100 slt
PCSrc  out  2  00 ALU, 01 ALUOut, 10 jump addr, 11 reg A
trap  out  1  illegal opcode trapped
instr_done  out  1  one-cycle pulse on final cycle of each instruction

Behaviour:
- Reset: clock, reset and polarity are fixed; reset is synchronous and active-high, on port rst sampled at posedge clk.
  - While rst=1, every output is 0.
  - State is FETCH on the first cycle after rst falls.
  - rst mid-instruction aborts immediately; no partial writes occur after the reset edge.
- Outputs not listed for a state are 0. "rdy" below means mem_ready when STALL_EN=1, otherwise constant 1.
- Opcodes:
  - RT = 000000, lw = 100011, sw = 101011
  - beq = 000100, bne = 000101
  - j = 000010, jal = 000011
  - addi = 001000, andi = 001100, slti = 001010
  - jr = OPC_JR
  - any other opcode is illegal.
- FETCH:
  - Outputs: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=000, PCSrc=00, IRWrite=rdy, PCWrite=rdy.
  - Stays in FETCH while !rdy; goes to DECODE when rdy.
- DECODE:
  - Outputs: ALUSrcA=0, ALUSrcB=11, ALUOp=000 (branch target into ALUOut).
  - Next state by opcode:
    - lw/sw -> MEMADR
    - RT -> RTEX
    - addi/andi/slti -> IMMEX
    - beq/bne -> BRANCH
    - j -> JUMP
    - jal -> JAL
    - jr -> JR
    - illegal -> TRAP if TRAP_EN, else FETCH with instr_done=1.
- MEMADR: ALUSrcA=1, ALUSrcB=10, ALUOp=000. Next: MEMRD for lw, MEMWR for sw.
- MEMRD: MemRead=1, IorD=1. Holds while !rdy, then goes to MEMWB.
- MEMWB: RegWrite=1, RegDst=0, MemToReg=1, instr_done=1. Next: FETCH.
- MEMWR: MemWrite=1, IorD=1. Holds while !rdy (MemWrite stays asserted). On rdy: instr_done=1 and next state FETCH.
- RTEX: ALUSrcA=1, ALUSrcB=00, ALUOp=010. Next: RTWB.
- RTWB: RegDst=1, RegWrite=1, instr_done=1. Next: FETCH.
- IMMEX: ALUSrcA=1, ALUSrcB=10, ALUOp=000/011/100 for addi/andi/slti. Next: IMMWB.
- IMMWB: RegDst=0, RegWrite=1, instr_done=1. Next: FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=001, PCSrc=01, PCWriteCondBeq=beq, PCWriteCondBne=bne, instr_done=1. Next: FETCH.
- JUMP: PCWrite=1, PCSrc=10, instr_done=1. Next: FETCH.
- JAL:
  - Outputs: PCWrite=1, PCSrc=10, RegWrite=1, JalSig1=1 (dest r31), JalSig2=1 (data = PC, already PC+4), instr_done=1. Next: FETCH.
  - The r31 write uses the pre-edge PC.
- JR: PCWrite=1, PCSrc=11, instr_done=1. Next: FETCH.
- TRAP:
  - trap=1; all other outputs 0.
  - Absorbing state: exits only via rst.
- Latencies with rdy always 1:
  - lw 5 cycles; sw 4; RT/imm 4; beq/bne/j/jal/jr 3.
  - Each wait cycle adds 1 in FETCH, MEMRD or MEMWR.
- mem_ready is ignored in all states other than FETCH, MEMRD and MEMWR.

Test Plan:
- rst=1 for 2 cycles, then release, mem_ready=1 -> outputs all 0 during reset; cycle 1 after release: MemRead=1, IRWrite=1, PCWrite=1, ALUSrcB=01.
- lw (100011), mem_ready low for 2 cycles in FETCH and 3 in MEMRD -> IRWrite pulses once, only on the rdy cycle; MemToReg=1 with RegWrite=1 in cycle 10; instr_done exactly once.
- slti (001010), then andi (001100) -> IMMEX shows ALUOp=100, then 011; IMMWB RegWrite=1, RegDst=0; 4 cycles each.
- jal (000011), then jr (000110) -> JAL cycle: PCWrite=1, PCSrc=10, RegWrite=1, JalSig1=1, JalSig2=1; JR cycle: PCSrc=11; 3 cycles each.
- opc=111111 with TRAP_EN=1 -> trap=1 from cycle 3 and held for 20 cycles with PCWrite=0; rst returns to FETCH. With TRAP_EN=0 -> FETCH at cycle 3 with instr_done=1.
- rst asserted in MEMWR while mem_ready=0 -> MemWrite=0 during reset, FETCH after release; STALL_EN=0 with mem_ready=0 -> sw completes in 4 cycles.
